// File: rtl/c7bexu_lsu_ctl_if.sv
// c7bexu_lsu_ctl_if: word-wide memory bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface c7bexu_lsu_ctl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_wresp;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_wresp
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata, bus_wresp
    );
endinterface

// File: rtl/c7bexu_lsu_ctl.sv
// c7bexu_lsu_ctl: load/store sequencer IDLE -> LS1 -> (LS2) -> LS3.
// Define C7BEXU_LSU_ALE_EN to enable the misaligned-access exception.
module c7bexu_lsu_ctl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lsu_vld_e,
    input  logic [3:0]  lsu_op_e,
    input  logic [31:0] lsu_addr_e,
    input  logic [31:0] lsu_wdata_e,
    c7bexu_lsu_ctl_if.master bus,
    output logic        lsu_except_ale_ls1,
    output logic [31:0] lsu_badv_ls1,
    output logic        lsu_data_valid_ls3,
    output logic [31:0] lsu_rdata_ls3,
    output logic        lsu_wr_fin_ls3,
    output logic        lsu_busy
);

    typedef enum logic [1:0] {IDLE, LS1, LS2, LS3} state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        is_byte, is_half, is_word;
    logic        misalign;
    logic        ale;
    logic        ld_done, st_done;
    logic [31:0] lane;
    logic [31:0] ld_ext;
    logic        sext;

    assign is_byte = (op_q[1:0] == 2'b00);
    assign is_half = (op_q[1:0] == 2'b01);
    assign is_word = op_q[1];
    assign sext    = ~op_q[2];

`ifdef C7BEXU_LSU_ALE_EN
    assign misalign = (is_half & addr_q[0]) | (is_word & (|addr_q[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign bus.bus_we   = op_q[3];
    assign bus.bus_addr = {addr_q[31:2], 2'b00};

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        bus.bus_wstrb = 4'b1111;
        bus.bus_wdata = wdata_q;
        unique case (1'b1)
            is_byte: begin
                bus.bus_wstrb = 4'b0001 << addr_q[1:0];
                bus.bus_wdata = {4{wdata_q[7:0]}};
            end
            is_half: begin
                bus.bus_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                bus.bus_wdata = {2{wdata_q[15:0]}};
            end
            is_word: begin
                bus.bus_wstrb = 4'b1111;
                bus.bus_wdata = wdata_q;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        lane   = bus.bus_rdata;
        ld_ext = bus.bus_rdata;
        unique case (1'b1)
            is_byte: begin
                lane   = bus.bus_rdata >> {addr_q[1:0], 3'b000};
                ld_ext = {{24{sext & lane[7]}}, lane[7:0]};
            end
            is_half: begin
                lane   = bus.bus_rdata >> {addr_q[1], 4'b0000};
                ld_ext = {{16{sext & lane[15]}}, lane[15:0]};
            end
            is_word: begin
                lane   = bus.bus_rdata;
                ld_ext = bus.bus_rdata;
            end
        endcase
    end

    // Next-state and per-state outputs
    always_comb begin
        state_nxt   = state;
        bus.bus_req = 1'b0;
        ale         = 1'b0;
        ld_done     = 1'b0;
        st_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (lsu_vld_e) state_nxt = LS1;
            end
            LS1: begin
                if (misalign) begin
                    ale       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bus.bus_req = 1'b1;
                    state_nxt   = bus.bus_gnt ? LS3 : LS2;
                end
            end
            LS2: begin
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) state_nxt = LS3;
            end
            LS3: begin
                if (op_q[3] && bus.bus_wresp) begin
                    st_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (!op_q[3] && bus.bus_rvalid) begin
                    ld_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign lsu_except_ale_ls1 = ale;
    assign lsu_badv_ls1       = ale ? addr_q : 32'h0;
    assign lsu_busy           = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Capture the issued access while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state == IDLE && lsu_vld_e) begin
            op_q    <= lsu_op_e;
            addr_q  <= lsu_addr_e;
            wdata_q <= lsu_wdata_e;
        end
    end

    // Completion pulses and held load result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lsu_data_valid_ls3 <= 1'b0;
            lsu_wr_fin_ls3     <= 1'b0;
            lsu_rdata_ls3      <= 32'h0;
        end else begin
            lsu_data_valid_ls3 <= ld_done;
            lsu_wr_fin_ls3     <= st_done;
            if (ld_done) lsu_rdata_ls3 <= ld_ext;
        end
    end

endmodule

// File: tb/tb_c7bexu_lsu_ctl.sv
// tb_c7bexu_lsu_ctl: directed and random accesses checked against
// a byte-level reference model of the LSU.
module tb_c7bexu_lsu_ctl;

`ifdef C7BEXU_LSU_ALE_EN
    localparam bit ALE = 1'b1;
`else
    localparam bit ALE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        lsu_vld_e = 1'b0;
    logic [3:0]  lsu_op_e = 4'h0;
    logic [31:0] lsu_addr_e = 32'h0;
    logic [31:0] lsu_wdata_e = 32'h0;
    logic        lsu_except_ale_ls1;
    logic [31:0] lsu_badv_ls1;
    logic        lsu_data_valid_ls3;
    logic [31:0] lsu_rdata_ls3;
    logic        lsu_wr_fin_ls3;
    logic        lsu_busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] prev_rd = 32'h0;

    c7bexu_lsu_ctl_if bus ();

    c7bexu_lsu_ctl dut (
        .clk                (clk),
        .resetn             (resetn),
        .lsu_vld_e          (lsu_vld_e),
        .lsu_op_e           (lsu_op_e),
        .lsu_addr_e         (lsu_addr_e),
        .lsu_wdata_e        (lsu_wdata_e),
        .bus                (bus),
        .lsu_except_ale_ls1 (lsu_except_ale_ls1),
        .lsu_badv_ls1       (lsu_badv_ls1),
        .lsu_data_valid_ls3 (lsu_data_valid_ls3),
        .lsu_rdata_ls3      (lsu_rdata_ls3),
        .lsu_wr_fin_ls3     (lsu_wr_fin_ls3),
        .lsu_busy           (lsu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Lane of the first byte of the size-aligned unit holding addr
    function automatic int base_lane(input logic [3:0] op, input logic [31:0] a);
        return int'(a % 4) - int'(a % nbytes(op));
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
        logic [3:0] s = 4'h0;
        for (int i = 0; i < nbytes(op); i++) s[base_lane(op, a) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] d = 32'h0;
        for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % nbytes(op)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v = 0;
        int n = nbytes(op);
        for (int i = 0; i < n; i++)
            v += longint'((rd >> (8 * (base_lane(op, a) + i))) & 32'hFF) << (8 * i);
        if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One access starting at a negedge with the DUT idle; returns at the
    // negedge where the completion pulse is visible.
    task automatic access(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rdl);
        bit st = op[3];
        bit mis = ALE && ((a % nbytes(op)) != 0);
        chk("idle_busy", {31'b0, lsu_busy}, 32'd0);
        lsu_vld_e   = 1'b1;
        lsu_op_e    = op;
        lsu_addr_e  = a;
        lsu_wdata_e = wd;
        @(negedge clk);
        lsu_vld_e   = 1'b0;
        lsu_op_e    = 4'($urandom);
        lsu_addr_e  = $urandom;
        lsu_wdata_e = $urandom;
        chk("ls1_busy", {31'b0, lsu_busy}, 32'd1);
        if (mis) begin
            chk("ale", {31'b0, lsu_except_ale_ls1}, 32'd1);
            chk("badv", lsu_badv_ls1, a);
            chk("ale_no_req", {31'b0, bus.bus_req}, 32'd0);
            @(negedge clk);
            chk("ale_pulse_end", {31'b0, lsu_except_ale_ls1}, 32'd0);
            chk("ale_badv_end", lsu_badv_ls1, 32'd0);
            chk("ale_idle", {31'b0, lsu_busy}, 32'd0);
            chk("ale_no_dv", {31'b0, lsu_data_valid_ls3}, 32'd0);
            chk("ale_no_wf", {31'b0, lsu_wr_fin_ls3}, 32'd0);
            return;
        end
        chk("ale_quiet", {31'b0, lsu_except_ale_ls1}, 32'd0);
        chk("badv_quiet", lsu_badv_ls1, 32'd0);
        for (int k = 0; k <= gd; k++) begin
            chk("req", {31'b0, bus.bus_req}, 32'd1);
            chk("addr", bus.bus_addr, a & 32'hFFFF_FFFC);
            chk("we", {31'b0, bus.bus_we}, {31'b0, st});
            if (st) begin
                chk("wstrb", {28'b0, bus.bus_wstrb}, {28'b0, m_strb(op, a)});
                chk("wdata", bus.bus_wdata, m_wdata(op, wd));
            end
            if (k == gd) bus.bus_gnt = 1'b1;
            if (k == 1) lsu_vld_e = 1'b1;
            @(negedge clk);
            bus.bus_gnt = 1'b0;
            lsu_vld_e   = 1'b0;
        end
        chk("ls3_no_req", {31'b0, bus.bus_req}, 32'd0);
        for (int k = 0; k <= rdl; k++) begin
            chk("ls3_busy", {31'b0, lsu_busy}, 32'd1);
            chk("ls3_no_dv", {31'b0, lsu_data_valid_ls3}, 32'd0);
            chk("ls3_no_wf", {31'b0, lsu_wr_fin_ls3}, 32'd0);
            if (k == rdl) begin
                if (st) bus.bus_wresp = 1'b1;
                else begin
                    bus.bus_rvalid = 1'b1;
                    bus.bus_rdata  = rd;
                end
            end else if (k == 0) begin
                if (st) begin
                    bus.bus_rvalid = 1'b1;
                    bus.bus_rdata  = $urandom;
                end else bus.bus_wresp = 1'b1;
            end
            @(negedge clk);
            bus.bus_rvalid = 1'b0;
            bus.bus_wresp  = 1'b0;
            bus.bus_rdata  = $urandom;
        end
        if (!st) prev_rd = m_load(op, a, rd);
        chk("dv", {31'b0, lsu_data_valid_ls3}, {31'b0, !st});
        chk("wf", {31'b0, lsu_wr_fin_ls3}, {31'b0, st});
        chk("rdata", lsu_rdata_ls3, prev_rd);
        chk("done_idle", {31'b0, lsu_busy}, 32'd0);
    endtask

    initial begin
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = 32'h0;
        bus.bus_wresp  = 1'b0;
        #12;
        chk("rst_req", {31'b0, bus.bus_req}, 32'd0);
        chk("rst_busy", {31'b0, lsu_busy}, 32'd0);
        chk("rst_ale", {31'b0, lsu_except_ale_ls1}, 32'd0);
        chk("rst_badv", lsu_badv_ls1, 32'd0);
        chk("rst_dv", {31'b0, lsu_data_valid_ls3}, 32'd0);
        chk("rst_wf", {31'b0, lsu_wr_fin_ls3}, 32'd0);
        chk("rst_rdata", lsu_rdata_ls3, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        access(4'b0010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1);
        access(4'b0000, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 0);
        access(4'b0100, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0);
        access(4'b1001, 32'h0000_2002, 32'h0000_1234, 32'h0, 3, 0);
        access(4'b0010, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0);
        access(4'b1000, 32'h0000_4001, 32'h0000_00A5, 32'h0, 2, 2);
        access(4'b0001, 32'h0000_4002, 32'h0, 32'h8765_4321, 0, 0);
        @(negedge clk);

        lsu_vld_e  = 1'b1;
        lsu_op_e   = 4'b0010;
        lsu_addr_e = 32'h0000_0040;
        @(negedge clk);
        lsu_vld_e   = 1'b0;
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        #1 resetn = 1'b0;
        #1;
        prev_rd = 32'h0;
        chk("mid_rst_busy", {31'b0, lsu_busy}, 32'd0);
        chk("mid_rst_req", {31'b0, bus.bus_req}, 32'd0);
        chk("mid_rst_rdata", lsu_rdata_ls3, 32'd0);
        @(negedge clk);
        resetn         = 1'b1;
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        chk("late_rvalid_dv", {31'b0, lsu_data_valid_ls3}, 32'd0);
        chk("late_rvalid_busy", {31'b0, lsu_busy}, 32'd0);
        @(negedge clk);
        chk("late_rvalid_dv2", {31'b0, lsu_data_valid_ls3}, 32'd0);

        repeat (300) begin
            access(4'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
